// File: rtl/alu_pkg.sv
// Shared definitions for the sequential ALU: opcode encodings and FSM states.
package alu_pkg;

  localparam logic [2:0] OP_ADD  = 3'd0;
  localparam logic [2:0] OP_SUB  = 3'd1;
  localparam logic [2:0] OP_NAND = 3'd2;
  localparam logic [2:0] OP_NOR  = 3'd3;
  localparam logic [2:0] OP_AND  = 3'd4;
  localparam logic [2:0] OP_OR   = 3'd5;
  localparam logic [2:0] OP_XOR  = 3'd6;
  localparam logic [2:0] OP_MUL  = 3'd7;

  // IDLE: output register empty; BUSY: multiply iterating; HOLD: result pending
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    HOLD = 2'd2
  } state_t;

endpackage

// File: rtl/alu_seq_if.sv
// Operand/result handshake bundle for alu_seq. The slave modport is the ALU,
// the master modport is the operand source plus result consumer.
interface alu_seq_if #(
  parameter int unsigned WIDTH = 4
) ();

  logic             in_valid;
  logic             in_ready;
  logic [2:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] y;
  logic [WIDTH-1:0] y_hi;
  logic             cout;
  logic             zero;
  logic             neg;
  logic             ovf;

  modport master (
    output in_valid, op, a, b, cin, out_ready,
    input  in_ready, out_valid, y, y_hi, cout, zero, neg, ovf
  );

  modport slave (
    input  in_valid, op, a, b, cin, out_ready,
    output in_ready, out_valid, y, y_hi, cout, zero, neg, ovf
  );

endinterface

// File: rtl/alu_core.sv
// Combinational datapath for the seven single-cycle opcodes. MUL is handled
// by the sequential unit in the top level, so this block returns zeros for it.
module alu_core
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic [WIDTH-1:0] y,
  output logic             cout,
  output logic             ovf
);

  logic [WIDTH:0] sum;
  logic [WIDTH:0] diff;

  // One extra bit so the top bit is carry-out for ADD and borrow-out for SUB
  assign sum  = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  assign diff = {1'b0, a} - {1'b0, b} - {{WIDTH{1'b0}}, cin};

  // Opcode select; signed overflow judged from operand and result sign bits
  always_comb begin
    y    = '0;
    cout = 1'b0;
    ovf  = 1'b0;
    case (op)
      OP_ADD: begin
        y    = sum[WIDTH-1:0];
        cout = sum[WIDTH];
        ovf  = (a[WIDTH-1] == b[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
      end
      OP_SUB: begin
        y    = diff[WIDTH-1:0];
        cout = diff[WIDTH];
        ovf  = (a[WIDTH-1] != b[WIDTH-1]) && (diff[WIDTH-1] != a[WIDTH-1]);
      end
      OP_NAND: y = ~(a & b);
      OP_NOR:  y = ~(a | b);
      OP_AND:  y = a & b;
      OP_OR:   y = a | b;
      OP_XOR:  y = a ^ b;
      default: ;
    endcase
  end

endmodule

// File: rtl/alu_seq.sv
// Handshaked sequential ALU: single-cycle logic/arithmetic via alu_core,
// WIDTH-cycle shift-add unsigned multiply, registered result and flags.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 4
) (
  input logic      clk,
  input logic      rst,
  alu_seq_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH);
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  state_t state_q;
  state_t state_d;

  logic in_ready;
  logic accept;
  logic is_mul;
  logic load_alu;
  logic start_mul;
  logic last_step;

  logic [WIDTH-1:0] core_y;
  logic             core_cout;
  logic             core_ovf;

  logic [2*WIDTH-1:0] mcand_q;
  logic [WIDTH-1:0]   mplier_q;
  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_step;
  logic [CW-1:0]      cnt_q;

  logic [WIDTH-1:0] y_q;
  logic [WIDTH-1:0] y_hi_q;
  logic             cout_q;
  logic             zero_q;
  logic             neg_q;
  logic             ovf_q;

  alu_core #(
    .WIDTH(WIDTH)
  ) u_core (
    .op  (bus.op),
    .a   (bus.a),
    .b   (bus.b),
    .cin (bus.cin),
    .y   (core_y),
    .cout(core_cout),
    .ovf (core_ovf)
  );

  assign in_ready  = !rst && ((state_q == IDLE) || ((state_q == HOLD) && bus.out_ready));
  assign accept    = bus.in_valid && in_ready;
  assign is_mul    = (bus.op == OP_MUL);
  assign last_step = (state_q == BUSY) && (cnt_q == LAST);

  // Partial product after the current step; on the last step this is the full product
  assign acc_step  = mplier_q[0] ? (acc_q + mcand_q) : acc_q;

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state and load strobes; accept can only fire in IDLE or a draining HOLD,
  // so it is handled once ahead of the per-state transitions
  always_comb begin
    state_d   = state_q;
    load_alu  = 1'b0;
    start_mul = 1'b0;
    if (accept) begin
      if (is_mul) begin
        state_d   = BUSY;
        start_mul = 1'b1;
      end else begin
        state_d   = HOLD;
        load_alu  = 1'b1;
      end
    end else begin
      case (state_q)
        BUSY:    if (last_step) state_d = HOLD;
        HOLD:    if (bus.out_ready) state_d = IDLE;
        default: ;
      endcase
    end
  end

  // Shift-add multiplier: multiplicand shifts left, multiplier shifts right
  always_ff @(posedge clk) begin
    if (rst) begin
      mcand_q  <= '0;
      mplier_q <= '0;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (start_mul) begin
      mcand_q  <= {{WIDTH{1'b0}}, bus.a};
      mplier_q <= bus.b;
      acc_q    <= '0;
      cnt_q    <= '0;
    end else if (state_q == BUSY) begin
      acc_q    <= acc_step;
      mcand_q  <= {mcand_q[2*WIDTH-2:0], 1'b0};
      mplier_q <= mplier_q >> 1;
      cnt_q    <= cnt_q + CW'(1);
    end
  end

  // Output register: loaded only on entry to HOLD, otherwise held
  always_ff @(posedge clk) begin
    if (rst) begin
      y_q    <= '0;
      y_hi_q <= '0;
      cout_q <= 1'b0;
      zero_q <= 1'b0;
      neg_q  <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (load_alu) begin
      y_q    <= core_y;
      y_hi_q <= '0;
      cout_q <= core_cout;
      zero_q <= (core_y == '0);
      neg_q  <= core_y[WIDTH-1];
      ovf_q  <= core_ovf;
    end else if (last_step) begin
      y_q    <= acc_step[WIDTH-1:0];
      y_hi_q <= acc_step[2*WIDTH-1:WIDTH];
      cout_q <= |acc_step[2*WIDTH-1:WIDTH];
      zero_q <= (acc_step == '0);
      neg_q  <= acc_step[WIDTH-1];
      ovf_q  <= 1'b0;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = (state_q == HOLD);
  assign bus.y         = y_q;
  assign bus.y_hi      = y_hi_q;
  assign bus.cout      = cout_q;
  assign bus.zero      = zero_q;
  assign bus.neg       = neg_q;
  assign bus.ovf       = ovf_q;

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq at WIDTH=4: directed vectors with literal
// expectations plus a queue-based reference model checked every valid cycle.
module tb_alu_seq;
  import alu_pkg::*;

  localparam int W   = 4;
  localparam int MOD = 1 << W;

  typedef struct {
    int y; int y_hi; int cout; int zero; int neg; int ovf;
  } exp_t;

  typedef struct {
    logic [2:0] op; int a; int b; int cin;
    int y; int cout; int zero; int neg; int ovf;
  } vec_t;

  logic clk = 1'b0;
  logic rst;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk),
    .rst(rst),
    .bus(bus)
  );

  always #5 clk = ~clk;

  int tests  = 0;
  int fails  = 0;
  int n_done = 0;
  exp_t exp_q[$];

  vec_t vecs[12] = '{
    '{OP_ADD,   3,  5, 0,  8, 0, 0, 1, 1},
    '{OP_SUB,   9,  3, 0,  6, 0, 0, 0, 1},
    '{OP_SUB,  15,  1, 1, 13, 0, 0, 1, 0},
    '{OP_SUB,   1,  2, 0, 15, 1, 0, 1, 0},
    '{OP_NAND, 12, 10, 0,  7, 0, 0, 0, 0},
    '{OP_NOR,  12, 10, 0,  1, 0, 0, 0, 0},
    '{OP_AND,  12, 10, 0,  8, 0, 0, 1, 0},
    '{OP_OR,   12, 10, 0, 14, 0, 0, 1, 0},
    '{OP_XOR,  12, 10, 0,  6, 0, 0, 0, 0},
    '{OP_XOR,   5,  5, 0,  0, 0, 1, 0, 0},
    '{OP_ADD,   7,  8, 1,  0, 1, 1, 0, 0},
    '{OP_AND,  15, 15, 1, 15, 0, 0, 1, 0}
  };

  function automatic void check(string name, int act, int req);
    tests++;
    if (act != req) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endfunction

  function automatic void fail_now(string name);
    tests++;
    fails++;
    $display("FAIL %s: no response within cycle budget (t=%0t)", name, $time);
  endfunction

  // Reference behaviour from plain integer arithmetic
  function automatic exp_t model(int op, int a, int b, int c);
    exp_t e;
    int sa, sb, r;
    e  = '{0, 0, 0, 0, 0, 0};
    sa = (a >= MOD / 2) ? a - MOD : a;
    sb = (b >= MOD / 2) ? b - MOD : b;
    case (op)
      0: begin
        r = a + b + c;
        e.y = r % MOD;
        e.cout = (r >= MOD);
        r = sa + sb + c;
        e.ovf = (r > MOD / 2 - 1) || (r < -MOD / 2);
      end
      1: begin
        r = a - b - c;
        e.y = (r + 2 * MOD) % MOD;
        e.cout = (r < 0);
        r = sa - sb - c;
        e.ovf = (r > MOD / 2 - 1) || (r < -MOD / 2);
      end
      2: e.y = (MOD - 1) - (a & b);
      3: e.y = (MOD - 1) - (a | b);
      4: e.y = a & b;
      5: e.y = a | b;
      6: e.y = a ^ b;
      default: begin
        r = a * b;
        e.y = r % MOD;
        e.y_hi = r / MOD;
        e.cout = (e.y_hi != 0);
      end
    endcase
    e.zero = (e.y == 0) && (e.y_hi == 0);
    e.neg  = (e.y >= MOD / 2);
    return e;
  endfunction

  // Compare process: every cycle with a pending result is checked against the model queue
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (bus.out_valid) begin
        check("mon_pending", (exp_q.size() > 0) ? 1 : 0, 1);
        if (exp_q.size() > 0) begin
          check("mon_y",    int'(bus.y),    exp_q[0].y);
          check("mon_y_hi", int'(bus.y_hi), exp_q[0].y_hi);
          check("mon_cout", int'(bus.cout), exp_q[0].cout);
          check("mon_zero", int'(bus.zero), exp_q[0].zero);
          check("mon_neg",  int'(bus.neg),  exp_q[0].neg);
          check("mon_ovf",  int'(bus.ovf),  exp_q[0].ovf);
          if (bus.out_ready) begin
            exp_q.delete(0);
            n_done++;
          end
        end
      end
      if (bus.in_valid && bus.in_ready)
        exp_q.push_back(model(int'(bus.op), int'(bus.a), int'(bus.b), int'(bus.cin)));
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [2:0] o, input int av, input int bv, input int c);
    int n;
    bus.in_valid = 1'b1;
    bus.op  = o;
    bus.a   = av[W-1:0];
    bus.b   = bv[W-1:0];
    bus.cin = c[0];
    n = 0;
    forever begin
      @(negedge clk);
      if (bus.in_ready) break;
      n++;
      if (n > 50) begin
        fail_now("accept_wait");
        break;
      end
    end
    step();
    bus.in_valid = 1'b0;
  endtask

  task automatic expect_out(string tag, int lat, int ey, int eyhi, int eco, int ez, int eng, int eov);
    int k;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!bus.out_valid && k < 20);
    check({tag, "_lat"},   k, lat);
    check({tag, "_valid"}, int'(bus.out_valid), 1);
    check({tag, "_y"},     int'(bus.y),    ey);
    check({tag, "_y_hi"},  int'(bus.y_hi), eyhi);
    check({tag, "_cout"},  int'(bus.cout), eco);
    check({tag, "_zero"},  int'(bus.zero), ez);
    check({tag, "_neg"},   int'(bus.neg),  eng);
    check({tag, "_ovf"},   int'(bus.ovf),  eov);
    step();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    exp_t e;
    int k, busy_low, base;

    rst = 1'b1;
    bus.in_valid = 1'b0;
    bus.op = '0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    bus.out_ready = 1'b0;

    // Reset state
    @(negedge clk);
    check("rst_in_ready", int'(bus.in_ready), 0);
    @(posedge clk);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rst_out_valid", int'(bus.out_valid), 0);
    check("rst_in_ready_after", int'(bus.in_ready), 1);
    check("rst_y", int'(bus.y), 0);
    check("rst_y_hi", int'(bus.y_hi), 0);
    check("rst_flags", int'({bus.cout, bus.zero, bus.neg, bus.ovf}), 0);
    step();

    // Single-cycle ops: literal expectations, also pinning the model
    bus.out_ready = 1'b1;
    for (int i = 0; i < 12; i++) begin
      e = model(int'(vecs[i].op), vecs[i].a, vecs[i].b, vecs[i].cin);
      check($sformatf("model_v%0d_y", i), e.y, vecs[i].y);
      check($sformatf("model_v%0d_cout", i), e.cout, vecs[i].cout);
      check($sformatf("model_v%0d_ovf", i), e.ovf, vecs[i].ovf);
      send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin);
      expect_out($sformatf("v%0d", i), 1, vecs[i].y, 0, vecs[i].cout,
                 vecs[i].zero, vecs[i].neg, vecs[i].ovf);
    end

    // MUL 15x15: latency and in_ready low through BUSY
    e = model(int'(OP_MUL), 15, 15, 0);
    check("model_mul_y_hi", e.y_hi, 14);
    bus.in_valid = 1'b1;
    bus.op = OP_MUL;
    bus.a = 4'hF;
    bus.b = 4'hF;
    bus.cin = 1'b0;
    @(negedge clk);
    check("mul_accept_ready", int'(bus.in_ready), 1);
    step();
    bus.in_valid = 1'b0;
    k = 0;
    busy_low = 0;
    while (k < 20) begin
      @(negedge clk);
      k++;
      if (bus.out_valid) break;
      if (!bus.in_ready) busy_low++;
    end
    check("mul_latency", k, 5);
    check("mul_busy_ready_low", busy_low, 4);
    check("mul_y", int'(bus.y), 1);
    check("mul_y_hi", int'(bus.y_hi), 14);
    check("mul_cout", int'(bus.cout), 1);
    check("mul_zero", int'(bus.zero), 0);
    step();

    send(OP_MUL, 0, 9, 1);
    expect_out("mul0", 5, 0, 0, 0, 1, 0, 0);
    send(OP_MUL, 3, 5, 0);
    expect_out("mul15", 5, 15, 0, 0, 0, 1, 0);
    send(OP_MUL, 13, 11, 0);
    expect_out("mul143", 5, 15, 8, 1, 0, 1, 0);

    // Backpressure: result held stable, new beat waits, then accepted with out_ready
    bus.out_ready = 1'b0;
    send(OP_ADD, 2, 3, 0);
    bus.in_valid = 1'b1;
    bus.op = OP_ADD;
    bus.a = 4'd1;
    bus.b = 4'd1;
    bus.cin = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check("bp_valid", int'(bus.out_valid), 1);
      check("bp_y", int'(bus.y), 5);
      check("bp_in_ready", int'(bus.in_ready), 0);
      step();
    end
    bus.out_ready = 1'b1;
    @(negedge clk);
    check("bp_release_ready", int'(bus.in_ready), 1);
    step();
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("bp_next_valid", int'(bus.out_valid), 1);
    check("bp_next_y", int'(bus.y), 3);
    step();

    // Reset two cycles into a multiply
    bus.in_valid = 1'b1;
    bus.op = OP_MUL;
    bus.a = 4'd3;
    bus.b = 4'd2;
    @(negedge clk);
    check("rm_accept_ready", int'(bus.in_ready), 1);
    step();
    bus.in_valid = 1'b0;
    step();
    step();
    rst = 1'b1;
    @(negedge clk);
    check("rm_in_ready_rst", int'(bus.in_ready), 0);
    step();
    rst = 1'b0;
    @(negedge clk);
    check("rm_out_valid", int'(bus.out_valid), 0);
    check("rm_in_ready", int'(bus.in_ready), 1);
    check("rm_y", int'(bus.y), 0);
    check("rm_y_hi", int'(bus.y_hi), 0);
    check("rm_flags", int'({bus.cout, bus.zero, bus.neg, bus.ovf}), 0);
    for (int i = 0; i < 8; i++) begin
      @(negedge clk);
      check("rm_no_stale_valid", int'(bus.out_valid), 0);
    end
    step();

    // Back-to-back ADD stream, one result per cycle checked by the model
    base = n_done;
    for (int i = 0; i < 8; i++) begin
      bus.in_valid = 1'b1;
      bus.op = OP_ADD;
      bus.a = 4'((3 * i + 1) % MOD);
      bus.b = 4'((15 - 2 * i + MOD) % MOD);
      bus.cin = i[0];
      @(negedge clk);
      check("st_in_ready", int'(bus.in_ready), 1);
      if (i > 0) check("st_valid", int'(bus.out_valid), 1);
      step();
    end
    bus.in_valid = 1'b0;
    @(negedge clk);
    check("st_last_valid", int'(bus.out_valid), 1);
    step();
    @(negedge clk);
    check("st_drained_valid", int'(bus.out_valid), 0);
    check("st_results", n_done - base, 8);
    check("st_queue_empty", exp_q.size(), 0);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
